i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 134 +++++++++++++
 tb/tb_i2s_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: 64-slot stereo frames (32 sclk per channel), MSB first, with a
// one-entry pending buffer, sample bypass at the frame load and sticky overflow/underrun flags.
package sample_pkg;
  localparam int DATA_WIDTH = 24;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] lc;
    logic [DATA_WIDTH-1:0] rc;
  } sample_t;
endpackage

module i2s_tx #(
  parameter int DATA_WIDTH = sample_pkg::DATA_WIDTH,
  parameter int SCLK_HALF  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  sample_pkg::sample_t data_i,
  input  logic                vld_i,
  input  logic                clr_i,
  output logic                sclk_o,
  output logic                lrck_o,
  output logic                sdat_o,
  output logic                frame_o,
  output logic                ovf_o,
  output logic                udf_o
);

  localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [CNT_W-1:0]      div_cnt;
  logic [5:0]            slot;
  logic [5:0]            slot_nxt;
  sample_pkg::sample_t   pend_q;
  sample_pkg::sample_t   act_q;
  sample_pkg::sample_t   load_val;
  sample_pkg::sample_t   word_src;
  logic                  full_q;
  logic                  wrap;
  logic                  fall;
  logic                  load;
  logic                  ovf_set;
  logic                  udf_set;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_sh;
  logic                  sdat_nxt;
  logic                  lrck_nxt;

  assign wrap     = (div_cnt == CNT_W'(SCLK_HALF - 1));
  assign fall     = wrap & sclk_o;
  assign slot_nxt = slot + 6'd1;
  assign load     = fall & (slot == 6'd63);

  // Pending wins over a same-cycle vld_i; with nothing available the frame is silent.
  always_comb begin
    load_val = '0;
    if (full_q) begin
      load_val = pend_q;
    end else if (vld_i) begin
      load_val = data_i;
    end
  end

  assign ovf_set = vld_i & full_q & ~load;
  assign udf_set = load & ~full_q & ~vld_i;

  // Slot 0 must already see the sample being loaded in the same edge.
  assign word_src = load ? load_val : act_q;
  assign word     = DATA_WIDTH'(slot_nxt[5] ? word_src.rc : word_src.lc);
  // Shifting past DATA_WIDTH yields the zero padding for the tail of each channel.
  assign word_sh  = word << slot_nxt[4:0];
  assign sdat_nxt = word_sh[DATA_WIDTH-1];
  assign lrck_nxt = (slot_nxt >= 6'd31) && (slot_nxt != 6'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= 6'd63;
      sclk_o  <= 1'b0;
      lrck_o  <= 1'b0;
      sdat_o  <= 1'b0;
      frame_o <= 1'b0;
      ovf_o   <= 1'b0;
      udf_o   <= 1'b0;
      pend_q  <= '0;
      act_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      frame_o <= load;

      if (wrap) begin
        div_cnt <= '0;
        sclk_o  <= ~sclk_o;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        slot   <= slot_nxt;
        lrck_o <= lrck_nxt;
        sdat_o <= sdat_nxt;
      end

      if (load) begin
        act_q <= load_val;
      end

      // At a load with pending full, a new sample refills pending and full stays set.
      if (load) begin
        if (vld_i && full_q) begin
          pend_q <= data_i;
        end else begin
          full_q <= 1'b0;
        end
      end else if (vld_i) begin
        pend_q <= data_i;
        full_q <= 1'b1;
      end

      if (ovf_set) begin
        ovf_o <= 1'b1;
      end else if (clr_i) begin
        ovf_o <= 1'b0;
      end

      if (udf_set) begin
        udf_o <= 1'b1;
      end else if (clr_i) begin
        udf_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a frame monitor collects 64 slots per frame at sclk rise
// and compares them against expected frames queued when stimulus is driven.
module tb_i2s_tx;

  localparam int DW    = 24;
  localparam int SH    = 2;
  localparam int FRAME = 64 * 2 * SH;
  localparam logic [63:0] LR_MASK = 64'h0000_0001_FFFF_FFFE;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  sample_pkg::sample_t data_i;
  logic                vld_i = 1'b0;
  logic                clr_i = 1'b0;
  logic                sclk_o;
  logic                lrck_o;
  logic                sdat_o;
  logic                frame_o;
  logic                ovf_o;
  logic                udf_o;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc_cnt   = 0;
  int last_load = 0;
  logic [63:0] exp_q[$];

  i2s_tx #(.DATA_WIDTH(DW), .SCLK_HALF(SH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .vld_i   (vld_i),
    .clr_i   (clr_i),
    .sclk_o  (sclk_o),
    .lrck_o  (lrck_o),
    .sdat_o  (sdat_o),
    .frame_o (frame_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [23:0] lc, input logic [23:0] rc);
    return {lc, 8'h00, rc, 8'h00};
  endfunction

  // Frame monitor: starts at frame_o, takes one bit per sclk rising edge.
  logic [63:0] mon_dat;
  logic [63:0] mon_lr;
  int          mon_slot = 0;
  bit          mon_on   = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [63:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_on    = 1'b0;
      sclk_prev = 1'b0;
    end else begin
      if (frame_o) begin
        mon_on   = 1'b1;
        mon_slot = 0;
        mon_dat  = '0;
        mon_lr   = '0;
      end else if (mon_on && sclk_o && !sclk_prev) begin
        mon_dat[63-mon_slot] = sdat_o;
        mon_lr[63-mon_slot]  = lrck_o;
        mon_slot++;
        if (mon_slot == 64) begin
          mon_on = 1'b0;
          check("frame_expected_available", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("frame_data", mon_dat, mon_exp);
          end
          check("frame_lrck", mon_lr, LR_MASK);
        end
      end
      sclk_prev = sclk_o;
    end
  end

  task automatic send(input logic [23:0] lc, input logic [23:0] rc);
    @(posedge clk); #1;
    data_i.lc = lc;
    data_i.rc = rc;
    vld_i     = 1'b1;
    @(posedge clk); #1;
    vld_i     = 1'b0;
  endtask

  task automatic wait_frame(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame_o && cycles < 2 * FRAME);
    check(tag, 64'(frame_o), 64'd1);
    last_load = cyc_cnt;
  endtask

  // Holds vld_i high exactly across the next frame-load edge.
  task automatic send_at_load(input logic [23:0] lc, input logic [23:0] rc);
    while (cyc_cnt < last_load + FRAME - 1) begin
      @(posedge clk); #1;
    end
    data_i.lc = lc;
    data_i.rc = rc;
    vld_i     = 1'b1;
    @(posedge clk); #1;
    vld_i     = 1'b0;
    @(negedge clk);
    check("coincident_load_frame_o", 64'(frame_o), 64'd1);
    last_load = cyc_cnt;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int prev_load;
    data_i = '0;

    // Reset state and sample queued before the first load
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({sclk_o, lrck_o, sdat_o, frame_o, ovf_o, udf_o}), 64'd0);
    rst_n = 1'b1;
    exp_q.push_back(frame_of(24'hA5A5A5, 24'h5A5A5A));
    exp_q.push_back(64'h0);
    send(24'hA5A5A5, 24'h5A5A5A);
    wait_frame("first_load", cyc);
    check("udf_after_fed_load", 64'(udf_o), 64'd0);
    check("ovf_after_fed_load", 64'(ovf_o), 64'd0);

    // Underrun load and frame period
    prev_load = last_load;
    wait_frame("underrun_load", cyc);
    check("frame_period", 64'(last_load - prev_load), 64'(FRAME));
    check("udf_after_underrun", 64'(udf_o), 64'd1);

    // Two samples in one frame: newest survives, overflow flagged
    repeat (20) @(posedge clk);
    send(24'h111111, 24'h222222);
    check("ovf_after_single_vld", 64'(ovf_o), 64'd0);
    send(24'h333333, 24'h444444);
    check("ovf_after_double_vld", 64'(ovf_o), 64'd1);
    exp_q.push_back(frame_of(24'h333333, 24'h444444));
    wait_frame("load_after_overflow", cyc);
    repeat (10) @(posedge clk);
    pulse_clr();
    check("flags_after_clr", 64'({ovf_o, udf_o}), 64'd0);

    // Bypass: pending empty, sample arrives in the load cycle
    exp_q.push_back(frame_of(24'h800000, 24'h000001));
    send_at_load(24'h800000, 24'h000001);
    check("udf_after_bypass", 64'(udf_o), 64'd0);

    // Pending full and a new sample in the load cycle: no overflow, both emitted in order
    repeat (30) @(posedge clk);
    send(24'hC0FFEE, 24'h123456);
    check("ovf_after_fill", 64'(ovf_o), 64'd0);
    exp_q.push_back(frame_of(24'hC0FFEE, 24'h123456));
    exp_q.push_back(frame_of(24'hFEDCBA, 24'h0F0F0F));
    send_at_load(24'hFEDCBA, 24'h0F0F0F);
    check("ovf_after_coincident_full", 64'(ovf_o), 64'd0);
    prev_load = last_load;
    wait_frame("load_from_refilled_pending", cyc);
    check("frame_period_2", 64'(last_load - prev_load), 64'(FRAME));
    check("ovf_after_refilled_load", 64'(ovf_o), 64'd0);
    check("udf_after_refilled_load", 64'(udf_o), 64'd0);
    exp_q.push_back(64'h0);
    wait_frame("underrun_before_reset", cyc);
    check("udf_before_reset", 64'(udf_o), 64'd1);

    // Asynchronous reset in slot 40 of a frame
    while (cyc_cnt < last_load + 40 * 2 * SH + 1) begin
      @(posedge clk); #1;
    end
    check("lrck_at_slot_40", 64'(lrck_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", 64'({sclk_o, lrck_o, sdat_o, frame_o, ovf_o, udf_o}), 64'd0);
    exp_q.delete();
    exp_q.push_back(64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame("load_after_reset", cyc);
    check("reset_release_latency", 64'(cyc), 64'(2 * SH));
    check("udf_after_reset_load", 64'(udf_o), 64'd1);

    // Set both flags, then clear them
    repeat (15) @(posedge clk);
    send(24'h0ABCDE, 24'h765432);
    send(24'hFFFFFF, 24'h000000);
    check("ovf_second_round", 64'(ovf_o), 64'd1);
    exp_q.push_back(frame_of(24'hFFFFFF, 24'h000000));
    pulse_clr();
    check("flags_after_second_clr", 64'({ovf_o, udf_o}), 64'd0);
    wait_frame("final_load", cyc);
    repeat (FRAME + 4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
